// File: rtl/alu_logical_arb_pkg.sv
// Shared definitions for alu_logical users: op codes, select mapping,
// illegal-op test and the arbiter sequencer state type.
package alu_logical_arb_pkg;

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_OR  = 3'd1;
  localparam logic [2:0] OP_XOR = 3'd2;
  localparam logic [2:0] OP_SLL = 3'd3;
  localparam logic [2:0] OP_SRA = 3'd4;
  localparam logic [2:0] OP_SRL = 3'd5;

  // {sel2,sel1,sel0} patterns understood by alu_logical
  localparam logic [2:0] SEL_AND = 3'b000;
  localparam logic [2:0] SEL_OR  = 3'b001;
  localparam logic [2:0] SEL_XOR = 3'b010;
  localparam logic [2:0] SEL_SLL = 3'b110;
  localparam logic [2:0] SEL_SRA = 3'b100;
  localparam logic [2:0] SEL_SRL = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_HOLD = 2'd2
  } arbState_t;

  // Codes 6 and 7 have no unit operation behind them
  function automatic logic isIllegalOp(input logic [2:0] op);
    return (op == 3'd6) || (op == 3'd7);
  endfunction

  // Illegal codes fall back to the AND pattern so the unit still sees a defined select
  function automatic logic [2:0] opToSel(input logic [2:0] op);
    logic [2:0] sel;
    case (op)
      OP_AND:  sel = SEL_AND;
      OP_OR:   sel = SEL_OR;
      OP_XOR:  sel = SEL_XOR;
      OP_SLL:  sel = SEL_SLL;
      OP_SRA:  sel = SEL_SRA;
      OP_SRL:  sel = SEL_SRL;
      default: sel = SEL_AND;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/alu_logical_arb_rr_arb2.sv
// Two-way round-robin arbiter. The pointer remembers who won last and
// only moves when the winning request is actually accepted downstream.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant
);

  logic r_lastGrant1;

  // Pick the single requester, or the one not served last when both ask
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = r_lastGrant1 ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  // Reset pretends requester 1 won last so requester 0 is favoured first
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lastGrant1 <= 1'b1;
    end else if (accept && (grant != 2'b00)) begin
      r_lastGrant1 <= grant[1];
    end
  end

endmodule

// File: rtl/alu_logical_arb.sv
// Arbiter/sequencer in front of the shared alu_logical unit: grants one of
// two requesters, drives the unit for one cycle from registered operands,
// and returns the registered result over a valid/ready response channel.
module alu_logical_arb
  import alu_logical_arb_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_data,
  output logic             resp_id,
  output logic             resp_err,
  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  output logic             alu_sel0,
  output logic             alu_sel1,
  output logic             alu_sel2,
  input  logic [WIDTH-1:0] alu_out
);

  arbState_t        r_state;
  arbState_t        w_nextState;
  logic             w_canAccept;
  logic             w_accept;
  logic [1:0]       w_grant;
  logic [2:0]       w_op;
  logic [WIDTH-1:0] r_in1;
  logic [WIDTH-1:0] r_in2;
  logic [2:0]       r_sel;
  logic             r_opId;
  logic             r_opErr;
  logic [WIDTH-1:0] r_respData;
  logic             r_respId;
  logic             r_respErr;

  rr_arb2 u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     ({req1_valid, req0_valid}),
    .accept  (w_accept),
    .grant   (w_grant)
  );

  // A new op may enter when idle, or when the held result leaves this cycle
  always_comb begin
    w_canAccept = reset_n & ((r_state == ST_IDLE) | ((r_state == ST_HOLD) & resp_ready));
    w_accept    = w_canAccept & (|w_grant);
    w_op        = w_grant[1] ? req1_op : req0_op;
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic: one EXEC cycle per op, then hold until consumed
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_nextState = ST_EXEC;
      ST_EXEC: w_nextState = ST_HOLD;
      ST_HOLD: if (resp_ready) w_nextState = w_accept ? ST_EXEC : ST_IDLE;
      default: w_nextState = ST_IDLE;
    endcase
  end

  // Handshake outputs derived from state and the current grant
  always_comb begin
    req0_ready = w_canAccept & w_grant[0];
    req1_ready = w_canAccept & w_grant[1];
    resp_valid = (r_state == ST_HOLD);
  end

  // Latch the winner's operands on accept; they keep driving the unit afterwards
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_in1   <= '0;
      r_in2   <= '0;
      r_sel   <= SEL_AND;
      r_opId  <= 1'b0;
      r_opErr <= 1'b0;
    end else if (w_accept) begin
      r_in1   <= w_grant[1] ? req1_a : req0_a;
      r_in2   <= w_grant[1] ? req1_b : req0_b;
      r_sel   <= isIllegalOp(w_op) ? SEL_AND : opToSel(w_op);
      r_opId  <= w_grant[1];
      r_opErr <= isIllegalOp(w_op);
    end
  end

  // Capture the unit result at the end of EXEC; illegal ops return zero
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_respData <= '0;
      r_respId   <= 1'b0;
      r_respErr  <= 1'b0;
    end else if (r_state == ST_EXEC) begin
      r_respData <= r_opErr ? '0 : alu_out;
      r_respId   <= r_opId;
      r_respErr  <= r_opErr;
    end
  end

  assign alu_in1   = r_in1;
  assign alu_in2   = r_in2;
  assign alu_sel0  = r_sel[0];
  assign alu_sel1  = r_sel[1];
  assign alu_sel2  = r_sel[2];
  assign resp_data = r_respData;
  assign resp_id   = r_respId;
  assign resp_err  = r_respErr;

endmodule
